// File: rtl/ai_traffic_scheduler.sv
// Per-frame AI car scheduler: moves/retires live cars, spawns at most one car per frame
// via round-robin pointer and cooldown. Optional macro AI_SPAWN_JITTER_EN adds random[7:10] to the cooldown reload.
module ai_traffic_scheduler #(
  parameter int unsigned NUM_CARS  = 4,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned Y_LIMIT   = 480,
  parameter int unsigned SPAWN_GAP = 30,
  parameter int unsigned X_MIN     = 160,
  parameter int unsigned X_MAX     = 448
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              frame_start,
  input  logic [0:10]                       random,
  output logic [0:NUM_CARS-1][0:4][0:10]    car_states,
  output logic [0:NUM_CARS-1]               active,
  output logic                              frame_done
);

  localparam int unsigned CW     = 11;
  localparam int unsigned PTR_W  = (NUM_CARS > 2) ? $clog2(NUM_CARS) : 1;
  localparam int unsigned CAND_W = PTR_W + 1;
  localparam int unsigned CD_W   = $clog2(SPAWN_GAP + 16) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SPAWN, S_PUBLISH} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_do_move;
  logic              w_do_spawn;
  logic              w_do_publish;

  logic              r_act [NUM_CARS];
  logic [CW-1:0]     r_x   [NUM_CARS];
  logic [CW-1:0]     r_y   [NUM_CARS];
  logic [CW-1:0]     w_y_next [NUM_CARS];
  logic [CD_W-1:0]   r_cd;
  logic [PTR_W-1:0]  r_rr;

  logic              w_found;
  logic [PTR_W-1:0]  w_slot;
  logic [PTR_W-1:0]  w_rr_next;
  logic [CW-1:0]     w_x_clamp;
  logic [CD_W-1:0]   w_reload;
  logic              w_spawn_go;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state: frame_start only honoured in IDLE, never queued
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:    if (frame_start) w_state_next = S_MOVE;
      S_MOVE:    w_state_next = S_SPAWN;
      S_SPAWN:   w_state_next = S_PUBLISH;
      S_PUBLISH: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // State decode
  always_comb begin
    w_do_move    = 1'b0;
    w_do_spawn   = 1'b0;
    w_do_publish = 1'b0;
    unique case (r_state)
      S_MOVE:    w_do_move    = 1'b1;
      S_SPAWN:   w_do_spawn   = 1'b1;
      S_PUBLISH: w_do_publish = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    for (int s = 0; s < NUM_CARS; s++) w_y_next[s] = r_y[s] + CW'(SPEED);
  end

  // First inactive slot searching upward from r_rr with wrap
  always_comb begin
    logic [CAND_W-1:0] w_cand;
    w_found = 1'b0;
    w_slot  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_CARS; k++) begin
      w_cand = CAND_W'(r_rr) + CAND_W'(k);
      if (w_cand >= CAND_W'(NUM_CARS)) w_cand = w_cand - CAND_W'(NUM_CARS);
      if (!w_found && !r_act[w_cand[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_slot  = w_cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_rr_next = (w_slot == PTR_W'(NUM_CARS - 1)) ? '0 : w_slot + PTR_W'(1);
    w_x_clamp = random;
    if (random < CW'(X_MIN))      w_x_clamp = CW'(X_MIN);
    else if (random > CW'(X_MAX)) w_x_clamp = CW'(X_MAX);
`ifdef AI_SPAWN_JITTER_EN
    w_reload = CD_W'(SPAWN_GAP) + CD_W'(random[7:10]);
`else
    w_reload = CD_W'(SPAWN_GAP);
`endif
    w_spawn_go = w_do_spawn && (r_cd == '0) && w_found;
  end

  // Slot state, cooldown and round-robin pointer
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cd <= '0;
      r_rr <= '0;
      for (int s = 0; s < NUM_CARS; s++) begin
        r_act[s] <= 1'b0;
        r_x[s]   <= '0;
        r_y[s]   <= '0;
      end
    end else begin
      if (w_do_move) begin
        for (int s = 0; s < NUM_CARS; s++) begin
          if (r_act[s]) begin
            if (w_y_next[s] >= CW'(Y_LIMIT)) begin
              r_act[s] <= 1'b0;
              r_y[s]   <= '0;
            end else begin
              r_y[s]   <= w_y_next[s];
            end
          end
        end
        if (r_cd != '0) r_cd <= r_cd - CD_W'(1);
      end
      if (w_spawn_go) begin
        r_act[w_slot] <= 1'b1;
        r_x[w_slot]   <= w_x_clamp;
        r_y[w_slot]   <= '0;
        r_rr          <= w_rr_next;
        r_cd          <= w_reload;
      end
    end
  end

  // Published view, updated only on the PUBLISH edge
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_done <= 1'b0;
      active     <= '0;
      for (int s = 0; s < NUM_CARS; s++) begin
        car_states[s][0] <= '0;
        car_states[s][1] <= '0;
        car_states[s][2] <= '0;
        car_states[s][3] <= CW'(32);
        car_states[s][4] <= CW'(36);
      end
    end else begin
      frame_done <= w_do_publish;
      if (w_do_publish) begin
        for (int s = 0; s < NUM_CARS; s++) begin
          active[s]        <= r_act[s];
          car_states[s][0] <= r_act[s] ? CW'(1) : '0;
          car_states[s][1] <= r_act[s] ? r_x[s] : '0;
          car_states[s][2] <= r_act[s] ? r_y[s] : '0;
          car_states[s][3] <= CW'(32);
          car_states[s][4] <= CW'(36);
        end
      end
    end
  end

endmodule
